echo_envelope_detector: RTL and testbench
=========================================

// Module: echo_envelope_detector
// PURPOSE
//  Sits downstream of receive_beamformer and upstream of time_of_flight.
//  Rectifies the beamformed waveform and smooths it with a moving average.
//  Blanks transmitter ring-down, then qualifies an echo with hysteresis and a hold count.
//  Reports the timestamp and peak of the first echo per burst, or a no-echo result.
// PARAMETERS
//  DATA_WIDTH    16       width of sample_in, envelope and thresholds
//  TIME_WIDTH    24       width of time_since_emission
//  MIDSCALE      16'h8000 zero level of sample_in (offset binary)
//  AVG_LOG2      3        log2 of moving-average window (8 samples)
//  HOLD_SAMPLES  4        consecutive valid samples >= threshold_hi needed to qualify
//  BLANK_CYCLES  1048576  cycles after burst_start during which detection is inhibited
//  TIMEOUT       16000000 time_since_emission value ending the search with no echo
// PORTS
//  clk_in              in   1   system clock (100 MHz)
//  rst_in              in   1   asynchronous active-low reset
//  burst_start         in   1   1-cycle pulse, new transmit burst; restarts measurement
//  sample_in           in   16  beamformed sample, unsigned offset binary
//  sample_valid_in     in   1   sample_in valid this cycle
//  time_since_emission in   24  cycles since last burst_start
//  threshold_hi_in     in   16  envelope level that arms detection
//  threshold_lo_in     in   16  envelope level that ends the echo
//  envelope_out        out  16  current smoothed envelope
//  echo_detected       out  1   level; high from qualification until next burst_start
//  echo_time_out       out  24  timestamp of first qualifying sample
//  echo_peak_out       out  16  max envelope seen during the echo
//  echo_found_out      out  1   1 = echo found, 0 = timeout; valid with echo_valid_out
//  echo_valid_out      out  1   1-cycle pulse, result ready; once per burst
// BEHAVIOUR
//  - Reset (rst_in=0, async): state IDLE; all outputs, buffer, sum and counters = 0.
//  - Rectify: r = |sample_in - MIDSCALE|, computed in 17-bit signed.
//    Max 32768 fits in 16 bits unsigned; no saturation needed.
//  - Averager: circular buffer of 2^AVG_LOG2 entries.
//    On each valid sample: sum += r - oldest, over DATA_WIDTH+AVG_LOG2 bits.
//    envelope_out = sum >> AVG_LOG2, registered 1 cycle after sample_valid_in.
//  - Effective lo threshold = min(threshold_lo_in, threshold_hi_in).
//    Thresholds are sampled at every compare.
//  - FSM (all transitions evaluated on valid samples unless noted):
//    IDLE -> BLANK on burst_start.
//    BLANK: averager runs, no detection.
//      -> ARMED when time_since_emission >= BLANK_CYCLES (any cycle).
//    ARMED: hold_cnt++ when envelope >= hi, else hold_cnt=0.
//      Latch time_since_emission of the sample that takes hold_cnt 0->1.
//      On hold_cnt == HOLD_SAMPLES -> ECHO: echo_detected=1, echo_time_out=latched time.
//      If time_since_emission == TIMEOUT (any cycle) -> DONE: echo_found_out=0, pulse echo_valid_out.
//    ECHO: echo_peak_out = max(echo_peak_out, envelope).
//      When envelope < lo -> DONE: echo_found_out=1, pulse echo_valid_out.
//      TIMEOUT in ECHO -> DONE with echo_found_out=1.
//    DONE: outputs held until burst_start.
//  - Latency: qualifying HOLD-th sample at cycle t -> echo_detected high at t+2.
//  - burst_start in any state: -> BLANK.
//    Clears buffer, sum, hold_cnt, echo_* and echo_detected next cycle.
//    envelope_out is also cleared.
//  - burst_start with sample_valid_in in the same cycle: burst_start wins; sample dropped.
//  - burst_start in the same cycle as the DONE transition: no echo_valid_out pulse.
//  - HOLD_SAMPLES=1 must work: qualify on the first sample >= hi.
// STRUCTURE
//  - sonar_pkg: DATA_WIDTH and TIME_WIDTH constants, echo_state_t enum {IDLE,BLANK,ARMED,ECHO,DONE}.
//  - Sub-module moving_average: buffer, write pointer and running sum; clear input driven by burst_start.
//  - FSM, hold counter and result registers stay in this module.
// TESTING
//  - Reset mid-ECHO -> all outputs 0, state IDLE; no echo_valid_out after release.
//  - Constant sample 0x8000, hi=100 -> timeout at TIMEOUT.
//    Expect echo_valid_out=1 with echo_found_out=0 and echo_detected=0.
//  - Burst of samples 0x8400 (r=1024) during blanking, hi=500 -> echo_detected stays 0.
//  - After blanking, inject 0x8400 starting at time 2000000, hi=500, lo=200:
//    -> echo_time_out = time of the first sample whose envelope >= 500.
//    -> echo_peak_out = 1024; DONE after envelope falls below 200.
//  - Alternate 0x8400 / 0x8000 around hi with HOLD=4 -> hold_cnt resets, no detection.
//  - burst_start coincident with sample_valid_in and with the DONE transition
//    -> sample dropped; no valid pulse; state BLANK.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared constants and state encoding for the sonar receive chain.
package sonar_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int TIME_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BLANK = 3'd1,
    ARMED = 3'd2,
    ECHO  = 3'd3,
    DONE  = 3'd4
  } echo_state_t;

endpackage

// File: rtl/moving_average.sv
// Boxcar average over 2^AVG_LOG2 samples: ring buffer plus running sum.
// The running sum is exact, so the average is sum >> AVG_LOG2 with no drift.
module moving_average #(
  parameter int DATA_WIDTH = sonar_pkg::DATA_WIDTH,
  parameter int AVG_LOG2   = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic [DATA_WIDTH-1:0] avg_o
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = DATA_WIDTH + AVG_LOG2;

  logic [DATA_WIDTH-1:0] ring_q [DEPTH];
  logic [AVG_LOG2-1:0]   wptr_q;
  logic [SW-1:0]         sum_q;
  logic [SW-1:0]         sum_d;

  // New sample enters, the one it overwrites (the oldest) leaves.
  assign sum_d = sum_q + SW'(sample_i) - SW'(ring_q[wptr_q]);

  // Ring buffer, pointer and sum; clear has priority over a same-cycle sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wptr_q <= '0;
      sum_q  <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
      wptr_q <= '0;
      sum_q  <= '0;
    end else if (valid_i) begin
      ring_q[wptr_q] <= sample_i;
      wptr_q         <= wptr_q + 1'b1;
      sum_q          <= sum_d;
    end
  end

  assign avg_o = sum_q[SW-1:AVG_LOG2];

endmodule

// File: rtl/echo_envelope_detector.sv
// Envelope detector: rectify, smooth, blank ring-down, then qualify the first
// echo of each burst with hysteresis and a hold count. One result per burst.
module echo_envelope_detector #(
  parameter int                    DATA_WIDTH   = sonar_pkg::DATA_WIDTH,
  parameter int                    TIME_WIDTH   = sonar_pkg::TIME_WIDTH,
  parameter logic [DATA_WIDTH-1:0] MIDSCALE     = {1'b1, {(DATA_WIDTH-1){1'b0}}},
  parameter int                    AVG_LOG2     = 3,
  parameter int                    HOLD_SAMPLES = 4,
  parameter int                    BLANK_CYCLES = 1048576,
  parameter int                    TIMEOUT      = 16000000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  burst_start,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic [TIME_WIDTH-1:0] time_since_emission,
  input  logic [DATA_WIDTH-1:0] threshold_hi_in,
  input  logic [DATA_WIDTH-1:0] threshold_lo_in,
  output logic [DATA_WIDTH-1:0] envelope_out,
  output logic                  echo_detected,
  output logic [TIME_WIDTH-1:0] echo_time_out,
  output logic [DATA_WIDTH-1:0] echo_peak_out,
  output logic                  echo_found_out,
  output logic                  echo_valid_out
);

  import sonar_pkg::echo_state_t;
  import sonar_pkg::IDLE;
  import sonar_pkg::BLANK;
  import sonar_pkg::ARMED;
  import sonar_pkg::ECHO;
  import sonar_pkg::DONE;

  localparam int HCW = $clog2(HOLD_SAMPLES + 1);

  // Rectifier: magnitude of the offset-binary sample around midscale.
  // The largest magnitude is MIDSCALE itself, which still fits in DATA_WIDTH.
  logic                  below_mid;
  logic [DATA_WIDTH-1:0] rect;
  assign below_mid = (sample_in < MIDSCALE);
  assign rect      = below_mid ? (MIDSCALE - sample_in) : (sample_in - MIDSCALE);

  logic [DATA_WIDTH-1:0] env;

  moving_average #(
    .DATA_WIDTH (DATA_WIDTH),
    .AVG_LOG2   (AVG_LOG2)
  ) u_avg (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_i  (burst_start),
    .valid_i  (sample_valid_in),
    .sample_i (rect),
    .avg_o    (env)
  );

  assign envelope_out = env;

  // The envelope of a sample appears one cycle later, so its valid flag and
  // timestamp are delayed alongside it; comparisons use this aligned pair.
  logic                  vld_q;
  logic [TIME_WIDTH-1:0] time_q;

  // Align sample valid/time with the registered envelope; a burst drops the sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_q  <= 1'b0;
      time_q <= '0;
    end else begin
      vld_q  <= sample_valid_in & ~burst_start;
      time_q <= time_since_emission;
    end
  end

  echo_state_t           state_q, state_d;
  logic [HCW-1:0]        hold_q, hold_d, hold_inc;
  logic [TIME_WIDTH-1:0] tlat_q, tlat_d;
  logic                  det_q, det_d;
  logic [TIME_WIDTH-1:0] etime_q, etime_d;
  logic [DATA_WIDTH-1:0] peak_q, peak_d;
  logic                  found_q, found_d;
  logic                  evalid_q, evalid_d;

  logic [DATA_WIDTH-1:0] lo_eff;
  logic                  blank_over, timeout_hit, env_ge_hi, env_lt_lo;

  // A lo threshold above hi would break hysteresis, so clamp it to hi.
  assign lo_eff      = (threshold_lo_in < threshold_hi_in) ? threshold_lo_in : threshold_hi_in;
  assign blank_over  = (time_since_emission >= TIME_WIDTH'(BLANK_CYCLES));
  assign timeout_hit = (time_since_emission == TIME_WIDTH'(TIMEOUT));
  assign env_ge_hi   = (env >= threshold_hi_in);
  assign env_lt_lo   = (env < lo_eff);
  assign hold_inc    = hold_q + 1'b1;

  // Next-state and result logic; burst_start overrides everything.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    tlat_d   = tlat_q;
    det_d    = det_q;
    etime_d  = etime_q;
    peak_d   = peak_q;
    found_d  = found_q;
    evalid_d = 1'b0;
    if (burst_start) begin
      state_d = BLANK;
      hold_d  = '0;
      tlat_d  = '0;
      det_d   = 1'b0;
      etime_d = '0;
      peak_d  = '0;
      found_d = 1'b0;
    end else begin
      case (state_q)
        BLANK: begin
          if (blank_over) state_d = ARMED;
        end
        ARMED: begin
          if (timeout_hit) begin
            state_d  = DONE;
            found_d  = 1'b0;
            evalid_d = 1'b1;
          end else if (vld_q) begin
            if (env_ge_hi) begin
              // First sample of a run carries the echo timestamp.
              if (hold_q == '0) tlat_d = time_q;
              if (hold_inc == HCW'(HOLD_SAMPLES)) begin
                state_d = ECHO;
                det_d   = 1'b1;
                etime_d = (hold_q == '0) ? time_q : tlat_q;
                peak_d  = env;
                hold_d  = '0;
              end else begin
                hold_d = hold_inc;
              end
            end else begin
              hold_d = '0;
            end
          end
        end
        ECHO: begin
          if (vld_q && (env > peak_q)) peak_d = env;
          if ((vld_q && env_lt_lo) || timeout_hit) begin
            state_d  = DONE;
            found_d  = 1'b1;
            evalid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, hold counter and result registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      tlat_q   <= '0;
      det_q    <= 1'b0;
      etime_q  <= '0;
      peak_q   <= '0;
      found_q  <= 1'b0;
      evalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      tlat_q   <= tlat_d;
      det_q    <= det_d;
      etime_q  <= etime_d;
      peak_q   <= peak_d;
      found_q  <= found_d;
      evalid_q <= evalid_d;
    end
  end

  assign echo_detected  = det_q;
  assign echo_time_out  = etime_q;
  assign echo_peak_out  = peak_q;
  assign echo_found_out = found_q;
  assign echo_valid_out = evalid_q;

endmodule

// File: tb/tb_echo_envelope_detector.sv
// Randomized bench for echo_envelope_detector with a sample-level reference model.
module tb_echo_envelope_detector;

  localparam int BLANK   = 1048576;
  localparam int TIMEOUT = 16000000;
  localparam int HOLD    = 4;
  localparam int MID     = 32768;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        burst_start;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic [23:0] time_since_emission;
  logic [15:0] threshold_hi_in;
  logic [15:0] threshold_lo_in;
  logic [15:0] envelope_out;
  logic        echo_detected;
  logic [23:0] echo_time_out;
  logic [15:0] echo_peak_out;
  logic        echo_found_out;
  logic        echo_valid_out;

  echo_envelope_detector dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .burst_start         (burst_start),
    .sample_in           (sample_in),
    .sample_valid_in     (sample_valid_in),
    .time_since_emission (time_since_emission),
    .threshold_hi_in     (threshold_hi_in),
    .threshold_lo_in     (threshold_lo_in),
    .envelope_out        (envelope_out),
    .echo_detected       (echo_detected),
    .echo_time_out       (echo_time_out),
    .echo_peak_out       (echo_peak_out),
    .echo_found_out      (echo_found_out),
    .echo_valid_out      (echo_valid_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- observation ----------------
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int vp_total = 0;
  int vp_found = 0;
  int rise_last = -1;
  bit det_prev = 1'b0;
  always @(negedge clk_in) begin
    if (echo_valid_out) begin
      vp_total = vp_total + 1;
      vp_found = echo_found_out;
    end
    if (echo_detected && !det_prev) rise_last = cyc;
    det_prev = echo_detected;
  end

  int vp_base;
  task automatic clr_trk();
    vp_base = vp_total;
  endtask

  // ---------------- reference model ----------------
  int win[$];
  int env_m;
  int hi_m, lo_m;
  bit m_active, m_found, m_done;
  int m_cnt, m_t0, m_time, m_peak, m_qcyc;

  function automatic int rect(input int s);
    return (s >= MID) ? s - MID : MID - s;
  endfunction

  task automatic m_clear();
    win = {};
    repeat (8) win.push_back(0);
    env_m = 0;
  endtask

  task automatic clr_model();
    m_found = 0; m_done = 0; m_cnt = 0; m_t0 = 0; m_time = 0; m_peak = 0; m_qcyc = 0;
  endtask

  task automatic m_push(input int r);
    int sum;
    void'(win.pop_front());
    win.push_back(r);
    sum = 0;
    foreach (win[k]) sum += win[k];
    env_m = sum / 8;
  endtask

  // Detection rules applied to one eligible sample whose envelope is env_m.
  task automatic m_eval(input int t);
    int lo_eff;
    lo_eff = (lo_m < hi_m) ? lo_m : hi_m;
    if (!m_found) begin
      if (env_m >= hi_m) begin
        if (m_cnt == 0) m_t0 = t;
        m_cnt++;
        if (m_cnt == HOLD) begin
          m_found = 1; m_time = m_t0; m_peak = env_m; m_qcyc = cyc;
        end
      end else begin
        m_cnt = 0;
      end
    end else if (!m_done) begin
      if (env_m > m_peak) m_peak = env_m;
      if (env_m < lo_eff) m_done = 1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Present one cycle of input; the envelope seen this cycle reflects earlier samples.
  task automatic drive_sample(input bit v, input int s, input int t);
    burst_start         = 1'b0;
    sample_valid_in     = v;
    sample_in           = 16'(s);
    time_since_emission = 24'(t);
    @(negedge clk_in);
    chk("envelope", envelope_out, env_m);
    if (!m_found) chk("det_early", echo_detected, 0);
    if (v) begin
      m_push(rect(s));
      if (m_active && t >= BLANK) m_eval(t);
    end
    tick();
  endtask

  task automatic start_burst();
    burst_start         = 1'b1;
    sample_valid_in     = 1'b0;
    time_since_emission = '0;
    m_clear();
    clr_model();
    clr_trk();
    m_active = 1;
    tick();
    burst_start = 1'b0;
  endtask

  task automatic set_thr(input int hi, input int lo);
    hi_m = hi; lo_m = lo;
    threshold_hi_in = 16'(hi);
    threshold_lo_in = 16'(lo);
  endtask

  // Blanking, armed search, then timeout; checks the single burst result.
  task automatic body(input int mode);
    int nb, na, t, s, a, amp, k;
    bit v;
    case (mode)
      1: begin nb = 5;  na = 12; set_thr(100, 50);  end
      2: begin nb = 6;  na = 36; set_thr(500, 200); end
      3: begin nb = 16; na = 20; set_thr(500, 200); end
      4: begin nb = 4;  na = 36; set_thr(600, 200); end
      default: begin
        nb = $urandom_range(4, 12);
        na = $urandom_range(20, 45);
        set_thr($urandom_range(300, 900), $urandom_range(50, 1000));
      end
    endcase
    amp = 0;
    for (int i = 0; i < nb + na; i++) begin
      k = i - nb;
      v = 1'b1;
      case (mode)
        2: a = (i >= nb && k < 12) ? 1024 : 0;
        3: a = (i < nb) ? 1024 : 0;
        4: a = (i >= nb && (k % 6) < 3) ? 1024 : 0;
        0: begin
          if (i % 5 == 0) begin
            case ($urandom_range(0, 5))
              0: amp = 0;    1: amp = 150;  2: amp = 400;
              3: amp = 700;  4: amp = 1024; default: amp = 1500;
            endcase
          end
          a = amp + $urandom_range(0, 40);
          v = ($urandom_range(0, 4) != 0);
        end
        default: a = 0;
      endcase
      s = (mode == 0 && $urandom_range(0, 1) == 1) ? MID - a : MID + a;
      t = (i < nb) ? i + 1 : 2000000 + k;
      drive_sample(v, s, t);
    end
    t = 2000000 + na;
    for (int j = 0; j < 3; j++) drive_sample(0, MID, t + j);
    drive_sample(0, MID, TIMEOUT);
    for (int j = 1; j < 4; j++) drive_sample(0, MID, TIMEOUT + j);
    @(negedge clk_in);
    chk("valid_pulses", vp_total - vp_base, 1);
    chk("found_at_pulse", vp_found, m_found);
    chk("found_level", echo_found_out, m_found);
    chk("detected", echo_detected, m_found);
    chk("echo_time", echo_time_out, m_found ? m_time : 0);
    chk("echo_peak", echo_peak_out, m_found ? m_peak : 0);
    if (m_found) chk("det_latency", rise_last - m_qcyc, 2);
    tick();
  endtask

  task automatic run_burst(input int mode);
    start_burst();
    body(mode);
  endtask

  // Drive a clean echo until the DUT sits in ECHO; returns next timestamp.
  task automatic drive_to_echo(output int t);
    set_thr(500, 200);
    for (int i = 0; i < 4; i++) drive_sample(1, MID, i + 1);
    t = 2000000;
    while (!m_found && t < 2000100) begin
      drive_sample(1, 16'h8400, t);
      t++;
    end
    drive_sample(1, 16'h8400, t);
    drive_sample(1, 16'h8400, t + 1);
    t = t + 2;
    chk("in_echo", echo_detected, 1);
  endtask

  task automatic collide_test();
    int t;
    start_burst();
    drive_to_echo(t);
    while (!m_done && t < 2000200) begin
      drive_sample(1, MID, t);
      t++;
    end
    // This cycle is the one that would move ECHO -> DONE.
    burst_start         = 1'b1;
    sample_valid_in     = 1'b1;
    sample_in           = 16'h8400;
    time_since_emission = '0;
    m_clear();
    clr_model();
    clr_trk();
    tick();
    burst_start     = 1'b0;
    sample_valid_in = 1'b0;
    @(negedge clk_in);
    chk("coll_no_pulse", vp_total - vp_base, 0);
    chk("coll_det", echo_detected, 0);
    chk("coll_env_dropped", envelope_out, 0);
    chk("coll_time", echo_time_out, 0);
    chk("coll_peak", echo_peak_out, 0);
    tick();
    body(2);
  endtask

  task automatic reset_mid_echo_test();
    int t;
    start_burst();
    drive_to_echo(t);
    rst_in = 1'b0;
    #1;
    chk("rst_env", envelope_out, 0);
    chk("rst_det", echo_detected, 0);
    chk("rst_time", echo_time_out, 0);
    chk("rst_peak", echo_peak_out, 0);
    chk("rst_found", echo_found_out, 0);
    chk("rst_valid", echo_valid_out, 0);
    sample_valid_in = 1'b0;
    tick();
    tick();
    rst_in = 1'b1;
    m_clear();
    clr_model();
    m_active = 0;
    clr_trk();
    for (int i = 0; i < 10; i++) drive_sample(1, 16'h8400, 2000000 + i);
    drive_sample(0, MID, TIMEOUT);
    for (int j = 1; j < 4; j++) drive_sample(0, MID, TIMEOUT + j);
    @(negedge clk_in);
    chk("idle_no_pulse", vp_total - vp_base, 0);
    chk("idle_det", echo_detected, 0);
    tick();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in              = 1'b0;
    burst_start         = 1'b0;
    sample_valid_in     = 1'b0;
    sample_in           = 16'h8000;
    time_since_emission = '0;
    threshold_hi_in     = '0;
    threshold_lo_in     = '0;
    hi_m = 0; lo_m = 0;
    m_active = 0;
    m_clear();
    clr_model();
    vp_base = 0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("reset_env", envelope_out, 0);
    chk("reset_det", echo_detected, 0);
    chk("reset_time", echo_time_out, 0);
    chk("reset_peak", echo_peak_out, 0);
    chk("reset_found", echo_found_out, 0);
    chk("reset_valid", echo_valid_out, 0);
    rst_in = 1'b1;
    tick();

    run_burst(1);   // silence -> timeout, no echo
    run_burst(2);   // clean echo after blanking
    run_burst(3);   // strong signal only inside blanking
    run_burst(4);   // pattern hovering around hi
    collide_test();
    reset_mid_echo_test();
    repeat (25) run_burst(0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
